// File: rtl/rgb2gray_stream.sv
// Streaming RGB->gray converter: 3-stage pipeline (products, sum, round/saturate) with a per-frame latched weight mode.
// A single advance signal stalls the whole pipe while the output is held, so IN_READY drops during backpressure.
module rgb2gray_stream #(
  parameter int PIX_W        = 8,
  parameter int FRAME_PIXELS = 40000,
  parameter int FCNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [PIX_W-1:0]  R,
  input  logic [PIX_W-1:0]  G,
  input  logic [PIX_W-1:0]  B,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [1:0]        MODE,
  output logic [PIX_W-1:0]  GRAY,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic [FCNT_W-1:0] FRAME_CNT
);

  localparam int IDX_W  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int PROD_W = PIX_W + 9;
  localparam int SUM_W  = PIX_W + 10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

  logic              en;
  logic              accept;
  logic              at_first;
  logic              at_last;
  logic [1:0]        eff_mode;
  logic [8:0]        wr, wg, wb;
  logic [SUM_W-1:0]  rounded;
  logic [SUM_W-1:0]  scaled;
  logic [PIX_W-1:0]  sat;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        mode_q, mode_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic              s1_vld_q, s1_vld_d;
  logic              s1_last_q, s1_last_d;
  logic [PROD_W-1:0] s1_pr_q, s1_pr_d;
  logic [PROD_W-1:0] s1_pg_q, s1_pg_d;
  logic [PROD_W-1:0] s1_pb_q, s1_pb_d;

  logic              s2_vld_q, s2_vld_d;
  logic              s2_last_q, s2_last_d;
  logic [SUM_W-1:0]  s2_sum_q, s2_sum_d;

  logic              s3_vld_q, s3_vld_d;
  logic              s3_last_q, s3_last_d;
  logic [PIX_W-1:0]  gray_q, gray_d;

  assign en        = !s3_vld_q || OUT_READY;
  assign accept    = IN_VALID && en;
  assign at_first  = (idx_q == '0);
  assign at_last   = (idx_q == LAST_IDX);
  // The first pixel of a frame must already use the MODE being latched with it.
  assign eff_mode  = at_first ? MODE : mode_q;

  assign IN_READY  = en;
  assign GRAY      = gray_q;
  assign OUT_VALID = s3_vld_q;
  assign OUT_LAST  = s3_last_q;
  assign FRAME_CNT = fcnt_q;

  // Weights out of 256; green passthrough is 256*G, which rounds back to G exactly.
  always_comb begin
    wr = 9'd77;
    wg = 9'd150;
    wb = 9'd29;
    case (eff_mode)
      2'd0: begin wr = 9'd77;  wg = 9'd150; wb = 9'd29;  end
      2'd1: begin wr = 9'd54;  wg = 9'd183; wb = 9'd19;  end
      2'd2: begin wr = 9'd85;  wg = 9'd85;  wb = 9'd85;  end
      default: begin wr = 9'd0; wg = 9'd256; wb = 9'd0; end
    endcase
  end

  always_comb begin
    rounded = s2_sum_q + SUM_W'(128);
    scaled  = rounded >> 8;
    if (|scaled[SUM_W-1:PIX_W]) begin
      sat = '1;
    end else begin
      sat = scaled[PIX_W-1:0];
    end
  end

  always_comb begin
    idx_d  = idx_q;
    mode_d = mode_q;
    fcnt_d = fcnt_q;
    if (accept) begin
      idx_d = at_last ? '0 : idx_q + 1'b1;
      if (at_first) begin
        mode_d = MODE;
      end
    end
    if (s3_vld_q && OUT_READY && s3_last_q) begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_last_d = s1_last_q;
    s1_pr_d   = s1_pr_q;
    s1_pg_d   = s1_pg_q;
    s1_pb_d   = s1_pb_q;
    s2_vld_d  = s2_vld_q;
    s2_last_d = s2_last_q;
    s2_sum_d  = s2_sum_q;
    s3_vld_d  = s3_vld_q;
    s3_last_d = s3_last_q;
    gray_d    = gray_q;
    if (en) begin
      s1_vld_d  = IN_VALID;
      s1_last_d = IN_VALID && at_last;
      if (IN_VALID) begin
        s1_pr_d = PROD_W'(wr) * PROD_W'(R);
        s1_pg_d = PROD_W'(wg) * PROD_W'(G);
        s1_pb_d = PROD_W'(wb) * PROD_W'(B);
      end
      s2_vld_d  = s1_vld_q;
      s2_last_d = s1_vld_q && s1_last_q;
      if (s1_vld_q) begin
        s2_sum_d = SUM_W'(s1_pr_q) + SUM_W'(s1_pg_q) + SUM_W'(s1_pb_q);
      end
      s3_vld_d  = s2_vld_q;
      s3_last_d = s2_vld_q && s2_last_q;
      if (s2_vld_q) begin
        gray_d = sat;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q     <= '0;
      mode_q    <= '0;
      fcnt_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_pr_q   <= '0;
      s1_pg_q   <= '0;
      s1_pb_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_sum_q  <= '0;
      s3_vld_q  <= 1'b0;
      s3_last_q <= 1'b0;
      gray_q    <= '0;
    end else begin
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      fcnt_q    <= fcnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s1_pr_q   <= s1_pr_d;
      s1_pg_q   <= s1_pg_d;
      s1_pb_q   <= s1_pb_d;
      s2_vld_q  <= s2_vld_d;
      s2_last_q <= s2_last_d;
      s2_sum_q  <= s2_sum_d;
      s3_vld_q  <= s3_vld_d;
      s3_last_q <= s3_last_d;
      gray_q    <= gray_d;
    end
  end

endmodule
